// File: rtl/pwr_reset_pkg.sv
// Shared types and constants for the sequenced power-up reset generator.
// Holds the sequencer state encoding and the default/limit parameter values.
package pwr_reset_pkg;

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    STRETCH = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } seq_state_t;

  localparam int DEF_CNT_W       = 6;
  localparam int DEF_GAP_W       = 3;
  localparam int MAX_NUM_CH      = 8;
  localparam int MIN_SYNC_STAGES = 2;

  // Width of the channel index, which must also hold NUM_CH itself.
  function automatic int ch_width(input int num_ch);
    return $clog2(num_ch + 1);
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Async-assert / sync-deassert reset conditioner: the output drops with rst_n
// immediately and rises only after SYNC_STAGES rising edges of clk7.
module reset_sync
  import pwr_reset_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk7,
  input  logic rst_n,
  output logic rst_n_sync
);

  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_stages
    $error("reset_sync: SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] sync_reg;

  always_ff @(posedge clk7 or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_n_sync = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/pwr_reset_seq.sv
// Sequenced reset generator: stretches a conditioned board reset, then
// releases NUM_CH active-high resets in index order with a fixed gap.
module pwr_reset_seq
  import pwr_reset_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int NUM_CH      = 3,
  parameter int GAP_W       = DEF_GAP_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk7,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              soft_rst_req,
  output logic [NUM_CH-1:0] rst,
  output logic              ready,
  output logic              busy
);

  localparam int              CH_W    = ch_width(NUM_CH);
  localparam logic [CH_W-1:0] FIRST_GAP_CH = CH_W'(1);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  if (NUM_CH < 1 || NUM_CH > MAX_NUM_CH) begin : g_bad_num_ch
    $error("pwr_reset_seq: NUM_CH must be in 1..8");
  end

  logic rst_n_sync;

  reset_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_reset_sync (
    .clk7      (clk7),
    .rst_n     (rst_n),
    .rst_n_sync(rst_n_sync)
  );

  seq_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg,   cnt_next;
  logic [GAP_W-1:0] gap_reg,   gap_next;
  logic [CH_W-1:0]  ch_reg,    ch_next;
  logic [NUM_CH-1:0] rst_reg,  rst_next;
  logic             ready_reg, ready_next;
  logic             busy_reg,  busy_next;

  // One-hot decode of the channel currently waiting for its gap to expire.
  logic [NUM_CH-1:0] ch_sel;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch_sel
    assign ch_sel[gi] = (ch_reg == CH_W'(gi));
  end

  logic restart;
  assign restart = soft_rst_req && (state_reg != SYNC);

  always_ff @(posedge clk7 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= SYNC;
      cnt_reg   <= '0;
      gap_reg   <= '0;
      ch_reg    <= '0;
      rst_reg   <= '1;
      ready_reg <= 1'b0;
      busy_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      gap_reg   <= gap_next;
      ch_reg    <= ch_next;
      rst_reg   <= rst_next;
      ready_reg <= ready_next;
      busy_reg  <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    gap_next   = gap_reg;
    ch_next    = ch_reg;
    rst_next   = rst_reg;
    ready_next = ready_reg;
    busy_next  = busy_reg;

    // A soft request wins over any terminal count on the same edge.
    if (restart) begin
      state_next = STRETCH;
      cnt_next   = '0;
      gap_next   = '0;
      ch_next    = '0;
      rst_next   = '1;
      ready_next = 1'b0;
      busy_next  = 1'b1;
    end else begin
      case (state_reg)
        SYNC: begin
          if (rst_n_sync) begin
            state_next = STRETCH;
            cnt_next   = '0;
          end
        end

        STRETCH: begin
          if (enable) begin
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == '1) begin
              rst_next[0] = 1'b0;
              gap_next    = '0;
              ch_next     = FIRST_GAP_CH;
              if (NUM_CH == 1) begin
                state_next = RUN;
                ready_next = 1'b1;
                busy_next  = 1'b0;
              end else begin
                state_next = RELEASE;
              end
            end
          end
        end

        RELEASE: begin
          if (enable) begin
            gap_next = gap_reg + 1'b1;
            if (gap_reg == '1) begin
              rst_next = rst_reg & ~ch_sel;
              ch_next  = ch_reg + 1'b1;
              if (ch_reg == LAST_CH) begin
                state_next = RUN;
                ready_next = 1'b1;
                busy_next  = 1'b0;
              end
            end
          end
        end

        RUN: begin
          rst_next   = '0;
          ready_next = 1'b1;
          busy_next  = 1'b0;
        end

        default: begin
          state_next = SYNC;
        end
      endcase
    end
  end

  assign rst   = rst_reg;
  assign ready = ready_reg;
  assign busy  = busy_reg;

endmodule

// File: tb/tb_pwr_reset_seq.sv
// Scoreboard bench for pwr_reset_seq: expected output changes (edge index and
// value) are queued when stimulus is applied and matched as the outputs move.
module tb_pwr_reset_seq;

  typedef struct packed {
    int unsigned edge_idx;
    logic [4:0]  snap;
  } ev_t;

  logic       clk7;
  logic       rst_n;
  logic       enable;
  logic       soft_rst_req;
  logic [2:0] rst;
  logic       ready;
  logic       busy;
  logic [0:0] rst1;
  logic       ready1;
  logic       busy1;

  int          total;
  int          bad;
  int unsigned cyc;
  bit          div_mode;
  logic [4:0]  prev0;
  logic [4:0]  prev1;
  ev_t         sb0[$];
  ev_t         sb1[$];

  pwr_reset_seq dut (
    .clk7        (clk7),
    .rst_n       (rst_n),
    .enable      (enable),
    .soft_rst_req(soft_rst_req),
    .rst         (rst),
    .ready       (ready),
    .busy        (busy)
  );

  pwr_reset_seq #(.NUM_CH(1)) dut1 (
    .clk7        (clk7),
    .rst_n       (rst_n),
    .enable      (enable),
    .soft_rst_req(soft_rst_req),
    .rst         (rst1),
    .ready       (ready1),
    .busy        (busy1)
  );

  initial clk7 = 1'b0;
  always #5 clk7 = ~clk7;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit en_at(input int unsigned k);
    return div_mode ? (k % 7 == 0) : 1'b1;
  endfunction

  // Edge index of the n-th enabled edge at or after edge 'from'.
  function automatic int unsigned nth_en(input int unsigned from, input int unsigned n);
    int unsigned got = 0;
    for (int unsigned k = from; k < from + 10000; k++) begin
      if (en_at(k)) begin
        got++;
        if (got == n) return k;
      end
    end
    return 0;
  endfunction

  task automatic observe();
    logic [4:0] cur0;
    logic [4:0] cur1;
    ev_t        e;
    cur0 = {rst, ready, busy};
    cur1 = {2'b00, rst1, ready1, busy1};
    if (cur0 !== prev0) begin
      if (sb0.size() == 0) begin
        check("dut0_spurious", cur0, prev0);
      end else begin
        e = sb0.pop_front();
        $display("edge %0d dut0 outs=%b", cyc, cur0);
        check("dut0_edge", cyc, e.edge_idx);
        check("dut0_outs", cur0, e.snap);
      end
      prev0 = cur0;
    end
    if (cur1 !== prev1) begin
      if (sb1.size() == 0) begin
        check("dut1_spurious", cur1, prev1);
      end else begin
        e = sb1.pop_front();
        $display("edge %0d dut1 outs=%b", cyc, cur1);
        check("dut1_edge", cyc, e.edge_idx);
        check("dut1_outs", cur1, e.snap);
      end
      prev1 = cur1;
    end
  endtask

  task automatic tick();
    @(negedge clk7);
    cyc++;
    observe();
    enable = en_at(cyc + 1);
  endtask

  // Queue the release events of a sequence whose first counting edge is 'start'.
  task automatic push_seq(input int unsigned start, input int nev);
    int unsigned t0;
    int unsigned t1;
    int unsigned t2;
    t0 = nth_en(start, 64);
    sb0.push_back('{t0, 5'b11001});
    sb1.push_back('{t0, 5'b00010});
    if (nev > 1) begin
      t1 = nth_en(t0 + 1, 8);
      t2 = nth_en(t1 + 1, 8);
      sb0.push_back('{t1, 5'b10001});
      sb0.push_back('{t2, 5'b00010});
    end
  endtask

  task automatic push_reassert(input int unsigned e);
    sb0.push_back('{e, 5'b11101});
    sb1.push_back('{e, 5'b00101});
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (sb0.size() + sb1.size()) != 0; i++) tick();
    check("drain", sb0.size() + sb1.size(), 0);
    sb0.delete();
    sb1.delete();
  endtask

  // 3 ns low pulse between edges; the outputs must react with no clock edge.
  task automatic async_pulse(input int nev);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst", rst, 3'b111);
    check("async_ready", ready, 1'b0);
    check("async_busy", busy, 1'b1);
    check("async_rst1", rst1, 1'b1);
    prev0 = {rst, ready, busy};
    prev1 = {2'b00, rst1, ready1, busy1};
    #2 rst_n = 1'b1;
    push_seq(cyc + 4, nev);
  endtask

  task automatic soft_pulse_run(input int nev);
    int unsigned c;
    soft_rst_req = 1'b1;
    c = cyc;
    push_reassert(c + 1);
    tick();
    soft_rst_req = 1'b0;
    if (nev > 0) push_seq(c + 2, nev);
  endtask

  initial begin
    int unsigned c;
    total = 0;
    bad = 0;
    cyc = 0;
    div_mode = 1'b0;
    rst_n = 1'b0;
    enable = 1'b1;
    soft_rst_req = 1'b0;
    prev0 = 5'b11101;
    prev1 = 5'b00101;

    // Held in reset.
    repeat (3) tick();
    check("reset_rst", rst, 3'b111);
    check("reset_ready", ready, 1'b0);
    check("reset_busy", busy, 1'b1);
    check("reset_rst1", rst1, 1'b1);
    check("reset_ready1", ready1, 1'b0);
    check("reset_busy1", busy1, 1'b1);

    // Power-up with enable tied high.
    rst_n = 1'b1;
    push_seq(cyc + 4, 3);
    drain(300);
    repeat (5) tick();

    // One-cycle soft request in RUN reruns the whole sequence.
    soft_pulse_run(3);
    drain(300);
    repeat (5) tick();

    // Divided clock enable (1 of 7) through a full power-up.
    div_mode = 1'b1;
    enable = en_at(cyc + 1);
    async_pulse(3);
    drain(1200);
    repeat (10) tick();
    div_mode = 1'b0;
    enable = en_at(cyc + 1);

    // Soft request held for 20 cycles during RELEASE.
    soft_pulse_run(1);
    drain(300);
    repeat (2) tick();
    soft_rst_req = 1'b1;
    c = cyc;
    push_reassert(c + 1);
    repeat (20) tick();
    soft_rst_req = 1'b0;
    push_seq(c + 21, 3);
    drain(300);
    repeat (5) tick();

    // Async pulse mid-STRETCH restarts with power-up latency.
    soft_pulse_run(0);
    repeat (20) tick();
    async_pulse(3);
    drain(300);
    repeat (5) tick();

    // Async pulse mid-RELEASE reasserts cleared bits immediately.
    soft_pulse_run(1);
    drain(300);
    repeat (2) tick();
    async_pulse(3);
    drain(300);
    repeat (5) tick();

    // Soft request on the terminal-count edge: nothing releases, count restarts.
    soft_pulse_run(0);
    c = cyc - 1;
    repeat (63) tick();
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    push_seq(c + 66, 3);
    drain(300);

    repeat (10) tick();
    check("final_ready", ready, 1'b1);
    check("final_busy1", busy1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
